// File: rtl/execute_stage.sv
// Execute stage: ID/EX capture, RAW forwarding from EX/MEM and write-back,
// ALU, and the EX/MEM register feeding the memory stage.
module execute_stage #(
    parameter int XLEN = 32,
    parameter int PC_W = 5,
    parameter int OP_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic [XLEN-1:0] in_read_data1,
    input  logic [XLEN-1:0] in_read_data2,
    input  logic [XLEN-1:0] in_imm,
    input  logic [4:0]      in_rs1,
    input  logic [4:0]      in_rs2,
    input  logic [4:0]      in_write_reg,
    input  logic            in_reg_wrenable,
    input  logic            in_is_jump,
    input  logic            in_mem_wrenable,
    input  logic            in_mem_to_reg,
    input  logic            in_alu_src,
    input  logic [OP_W-1:0] in_alu_op,
    input  logic [PC_W-1:0] in_pc,
    input  logic [4:0]      wb_write_reg,
    input  logic [XLEN-1:0] wb_write_data,
    input  logic            wb_reg_wrenable,
    output logic [XLEN-1:0] out_alu_result,
    output logic [XLEN-1:0] out_store_data,
    output logic [4:0]      out_write_reg,
    output logic            out_reg_wrenable,
    output logic            out_mem_wrenable,
    output logic            out_mem_to_reg
);

    localparam logic [OP_W-1:0] OP_ADD   = OP_W'(0);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'(1);
    localparam logic [OP_W-1:0] OP_AND   = OP_W'(2);
    localparam logic [OP_W-1:0] OP_OR    = OP_W'(3);
    localparam logic [OP_W-1:0] OP_XOR   = OP_W'(4);
    localparam logic [OP_W-1:0] OP_SLL   = OP_W'(5);
    localparam logic [OP_W-1:0] OP_SRL   = OP_W'(6);
    localparam logic [OP_W-1:0] OP_SRA   = OP_W'(7);
    localparam logic [OP_W-1:0] OP_SLT   = OP_W'(8);
    localparam logic [OP_W-1:0] OP_SLTU  = OP_W'(9);
    localparam logic [OP_W-1:0] OP_PASSB = OP_W'(10);
    localparam logic [XLEN-1:0] ZERO_X   = {XLEN{1'b0}};
    localparam logic [PC_W-1:0] PC_ONE   = PC_W'(1);

    logic [XLEN-1:0] idex_rd1_r, idex_rd2_r, idex_imm_r;
    logic [4:0]      idex_rs1_r, idex_rs2_r, idex_rd_r;
    logic            idex_reg_we_r, idex_is_jump_r, idex_mem_we_r, idex_mem_to_reg_r, idex_alu_src_r;
    logic [OP_W-1:0] idex_alu_op_r;
    logic [PC_W-1:0] idex_pc_r;

    logic [XLEN-1:0] fwd_a_s, fwd_b_s, op_b_s, alu_s, result_s;
    logic [PC_W-1:0] pc_plus1_s;
    logic [4:0]      shamt_s;
    logic            exm_fwd_en_s;

    // Operand source select: x0 is hard zero, EX/MEM beats WB, else the captured regfile value.
    function automatic logic [XLEN-1:0] forward(
        input logic [4:0]      rs,
        input logic [XLEN-1:0] captured,
        input logic            exm_en,
        input logic [4:0]      exm_rd,
        input logic [XLEN-1:0] exm_val,
        input logic            wb_en,
        input logic [4:0]      wb_rd,
        input logic [XLEN-1:0] wb_val
    );
        logic [XLEN-1:0] v;
        if (rs == 5'd0) begin
            v = ZERO_X;
        end else if (exm_en && (exm_rd == rs)) begin
            v = exm_val;
        end else if (wb_en && (wb_rd == rs)) begin
            v = wb_val;
        end else begin
            v = captured;
        end
        return v;
    endfunction

    // ID/EX register; a flush loads an all-zero bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            idex_rd1_r        <= ZERO_X;
            idex_rd2_r        <= ZERO_X;
            idex_imm_r        <= ZERO_X;
            idex_rs1_r        <= 5'd0;
            idex_rs2_r        <= 5'd0;
            idex_rd_r         <= 5'd0;
            idex_reg_we_r     <= 1'b0;
            idex_is_jump_r    <= 1'b0;
            idex_mem_we_r     <= 1'b0;
            idex_mem_to_reg_r <= 1'b0;
            idex_alu_src_r    <= 1'b0;
            idex_alu_op_r     <= {OP_W{1'b0}};
            idex_pc_r         <= {PC_W{1'b0}};
        end else begin
            idex_rd1_r        <= in_read_data1;
            idex_rd2_r        <= in_read_data2;
            idex_imm_r        <= in_imm;
            idex_rs1_r        <= in_rs1;
            idex_rs2_r        <= in_rs2;
            idex_rd_r         <= in_write_reg;
            idex_reg_we_r     <= in_reg_wrenable;
            idex_is_jump_r    <= in_is_jump;
            idex_mem_we_r     <= in_mem_wrenable;
            idex_mem_to_reg_r <= in_mem_to_reg;
            idex_alu_src_r    <= in_alu_src;
            idex_alu_op_r     <= in_alu_op;
            idex_pc_r         <= in_pc;
        end
    end

    // Forwarded operands; a load in EX/MEM has no data yet, so it is not a forward source.
    always_comb begin
        exm_fwd_en_s = out_reg_wrenable && !out_mem_to_reg;
        fwd_a_s = forward(idex_rs1_r, idex_rd1_r, exm_fwd_en_s, out_write_reg, out_alu_result,
                          wb_reg_wrenable, wb_write_reg, wb_write_data);
        fwd_b_s = forward(idex_rs2_r, idex_rd2_r, exm_fwd_en_s, out_write_reg, out_alu_result,
                          wb_reg_wrenable, wb_write_reg, wb_write_data);
        op_b_s  = idex_alu_src_r ? idex_imm_r : fwd_b_s;
        shamt_s = op_b_s[4:0];
    end

    // ALU; jumps override the operation with the link address.
    always_comb begin
        alu_s = ZERO_X;
        case (idex_alu_op_r)
            OP_ADD:   alu_s = fwd_a_s + op_b_s;
            OP_SUB:   alu_s = fwd_a_s - op_b_s;
            OP_AND:   alu_s = fwd_a_s & op_b_s;
            OP_OR:    alu_s = fwd_a_s | op_b_s;
            OP_XOR:   alu_s = fwd_a_s ^ op_b_s;
            OP_SLL:   alu_s = fwd_a_s << shamt_s;
            OP_SRL:   alu_s = fwd_a_s >> shamt_s;
            OP_SRA:   alu_s = $unsigned($signed(fwd_a_s) >>> shamt_s);
            OP_SLT:   alu_s = {{(XLEN-1){1'b0}}, ($signed(fwd_a_s) < $signed(op_b_s))};
            OP_SLTU:  alu_s = {{(XLEN-1){1'b0}}, (fwd_a_s < op_b_s)};
            OP_PASSB: alu_s = op_b_s;
            default:  alu_s = ZERO_X;
        endcase
        pc_plus1_s = idex_pc_r + PC_ONE;
        if (idex_is_jump_r) begin
            result_s = XLEN'(pc_plus1_s);
        end else begin
            result_s = alu_s;
        end
    end

    // EX/MEM register driving the stage outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_alu_result   <= ZERO_X;
            out_store_data   <= ZERO_X;
            out_write_reg    <= 5'd0;
            out_reg_wrenable <= 1'b0;
            out_mem_wrenable <= 1'b0;
            out_mem_to_reg   <= 1'b0;
        end else begin
            out_alu_result   <= result_s;
            out_store_data   <= fwd_b_s;
            out_write_reg    <= idex_rd_r;
            out_reg_wrenable <= idex_reg_we_r;
            out_mem_wrenable <= idex_mem_we_r;
            out_mem_to_reg   <= idex_mem_to_reg_r;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Directed self-checking bench for execute_stage: reset, forwarding, x0, jump/flush, ALU.
module tb_execute_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [31:0] in_read_data1, in_read_data2, in_imm;
    logic [4:0]  in_rs1, in_rs2, in_write_reg;
    logic        in_reg_wrenable, in_is_jump, in_mem_wrenable, in_mem_to_reg, in_alu_src;
    logic [4:0]  in_alu_op;
    logic [4:0]  in_pc;
    logic [4:0]  wb_write_reg;
    logic [31:0] wb_write_data;
    logic        wb_reg_wrenable;
    logic [31:0] out_alu_result, out_store_data;
    logic [4:0]  out_write_reg;
    logic        out_reg_wrenable, out_mem_wrenable, out_mem_to_reg;

    int checks = 0;
    int errors = 0;

    execute_stage #(.XLEN(32), .PC_W(5), .OP_W(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_read_data1(in_read_data1), .in_read_data2(in_read_data2), .in_imm(in_imm),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_write_reg(in_write_reg),
        .in_reg_wrenable(in_reg_wrenable), .in_is_jump(in_is_jump),
        .in_mem_wrenable(in_mem_wrenable), .in_mem_to_reg(in_mem_to_reg),
        .in_alu_src(in_alu_src), .in_alu_op(in_alu_op), .in_pc(in_pc),
        .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data),
        .wb_reg_wrenable(wb_reg_wrenable),
        .out_alu_result(out_alu_result), .out_store_data(out_store_data),
        .out_write_reg(out_write_reg), .out_reg_wrenable(out_reg_wrenable),
        .out_mem_wrenable(out_mem_wrenable), .out_mem_to_reg(out_mem_to_reg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic clear_inputs();
        flush = 1'b0;
        in_read_data1 = 32'd0; in_read_data2 = 32'd0; in_imm = 32'd0;
        in_rs1 = 5'd0; in_rs2 = 5'd0; in_write_reg = 5'd0;
        in_reg_wrenable = 1'b0; in_is_jump = 1'b0; in_mem_wrenable = 1'b0;
        in_mem_to_reg = 1'b0; in_alu_src = 1'b0; in_alu_op = 5'd0; in_pc = 5'd0;
        wb_write_reg = 5'd0; wb_write_data = 32'd0; wb_reg_wrenable = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        checks++;
        if ({out_alu_result, out_store_data, out_write_reg, out_reg_wrenable, out_mem_wrenable, out_mem_to_reg} !== 72'd0) begin
            errors++;
            $display("FAIL reset_initial: outputs=%h expected all zero",
                     {out_alu_result, out_store_data, out_write_reg, out_reg_wrenable, out_mem_wrenable, out_mem_to_reg});
        end
        rst = 1'b0;
        in_rs1 = 5'd2; in_read_data1 = 32'd10; in_imm = 32'd5; in_alu_src = 1'b1;
        in_rs2 = 5'd6; in_read_data2 = 32'h1234; in_write_reg = 5'd3; in_reg_wrenable = 1'b1;
        tick();
        tick();
        checks++;
        if (out_alu_result !== 32'd15 || out_store_data !== 32'h1234 || out_reg_wrenable !== 1'b1) begin
            errors++;
            $display("FAIL reset_prerun: result=%0d store=%h we=%b expected 15 1234 1",
                     out_alu_result, out_store_data, out_reg_wrenable);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({out_alu_result, out_store_data, out_write_reg, out_reg_wrenable, out_mem_wrenable, out_mem_to_reg} !== 72'd0) begin
            errors++;
            $display("FAIL reset_async: outputs=%h expected all zero",
                     {out_alu_result, out_store_data, out_write_reg, out_reg_wrenable, out_mem_wrenable, out_mem_to_reg});
        end
        tick();
        rst = 1'b0;
        in_rs2 = 5'd0; in_read_data2 = 32'd0;
        tick();
        checks++;
        if (out_alu_result !== 32'd0 || out_reg_wrenable !== 1'b0) begin
            errors++;
            $display("FAIL reset_latency: result=%0d we=%b expected 0 0 after one edge", out_alu_result, out_reg_wrenable);
        end
        clear_inputs();
        tick();
        checks++;
        if (out_alu_result !== 32'd15 || out_write_reg !== 5'd3) begin
            errors++;
            $display("FAIL reset_add_imm: result=%0d rd=%0d expected 15 3", out_alu_result, out_write_reg);
        end
    endtask

    task automatic test_back_to_back();
        clear_inputs();
        in_rs1 = 5'd5; in_read_data1 = 32'd3; in_rs2 = 5'd6; in_read_data2 = 32'd4;
        in_write_reg = 5'd1; in_reg_wrenable = 1'b1; in_alu_op = 5'd0;
        tick();
        clear_inputs();
        in_rs1 = 5'd1; in_read_data1 = 32'd0; in_imm = 32'd1; in_alu_src = 1'b1;
        in_alu_op = 5'd1; in_write_reg = 5'd2; in_reg_wrenable = 1'b1;
        tick();
        checks++;
        if (out_alu_result !== 32'd7) begin
            errors++;
            $display("FAIL b2b_add: got %0d expected 7", out_alu_result);
        end
        clear_inputs();
        in_rs1 = 5'd2; in_rs2 = 5'd2; in_read_data1 = 32'd99; in_read_data2 = 32'd98;
        in_alu_op = 5'd0; in_write_reg = 5'd8; in_reg_wrenable = 1'b1;
        tick();
        checks++;
        if (out_alu_result !== 32'd6) begin
            errors++;
            $display("FAIL b2b_sub_fwd: got %0d expected 6", out_alu_result);
        end
        clear_inputs();
        tick();
        checks++;
        if (out_alu_result !== 32'd12 || out_store_data !== 32'd6) begin
            errors++;
            $display("FAIL b2b_same_rs: result=%0d store=%0d expected 12 6", out_alu_result, out_store_data);
        end
    endtask

    task automatic test_wb_forward();
        clear_inputs();
        tick();
        in_rs1 = 5'd1; in_imm = 32'd0; in_alu_src = 1'b1; in_write_reg = 5'd4; in_reg_wrenable = 1'b1;
        tick();
        clear_inputs();
        wb_reg_wrenable = 1'b1; wb_write_reg = 5'd1; wb_write_data = 32'd100;
        tick();
        checks++;
        if (out_alu_result !== 32'd100) begin
            errors++;
            $display("FAIL wb_fwd: got %0d expected 100", out_alu_result);
        end
        clear_inputs();
        in_imm = 32'd7; in_alu_src = 1'b1; in_write_reg = 5'd1; in_reg_wrenable = 1'b1;
        tick();
        clear_inputs();
        in_rs1 = 5'd1; in_alu_src = 1'b1; in_write_reg = 5'd4; in_reg_wrenable = 1'b1;
        tick();
        clear_inputs();
        wb_reg_wrenable = 1'b1; wb_write_reg = 5'd1; wb_write_data = 32'd100;
        tick();
        checks++;
        if (out_alu_result !== 32'd7) begin
            errors++;
            $display("FAIL wb_priority: got %0d expected 7", out_alu_result);
        end
        clear_inputs();
    endtask

    task automatic test_x0();
        clear_inputs();
        in_imm = 32'd55; in_alu_src = 1'b1; in_write_reg = 5'd0; in_reg_wrenable = 1'b1;
        tick();
        clear_inputs();
        in_rs1 = 5'd0; in_read_data1 = 32'd123; in_alu_src = 1'b1; in_write_reg = 5'd7; in_reg_wrenable = 1'b1;
        tick();
        checks++;
        if (out_alu_result !== 32'd55 || out_write_reg !== 5'd0) begin
            errors++;
            $display("FAIL x0_write: result=%0d rd=%0d expected 55 0", out_alu_result, out_write_reg);
        end
        clear_inputs();
        wb_reg_wrenable = 1'b1; wb_write_reg = 5'd0; wb_write_data = 32'd99;
        tick();
        checks++;
        if (out_alu_result !== 32'd0) begin
            errors++;
            $display("FAIL x0_read: got %0d expected 0", out_alu_result);
        end
        clear_inputs();
    endtask

    task automatic test_jump_flush();
        clear_inputs();
        in_is_jump = 1'b1; in_pc = 5'd31; in_alu_op = 5'd3; in_read_data1 = 32'hFF; in_rs1 = 5'd9;
        in_write_reg = 5'd1; in_reg_wrenable = 1'b1;
        tick();
        clear_inputs();
        flush = 1'b1; in_reg_wrenable = 1'b1; in_mem_wrenable = 1'b1; in_mem_to_reg = 1'b1;
        in_write_reg = 5'd6; in_imm = 32'd9; in_alu_src = 1'b1;
        tick();
        checks++;
        if (out_alu_result !== 32'd0 || out_reg_wrenable !== 1'b1 || out_write_reg !== 5'd1) begin
            errors++;
            $display("FAIL jal_wrap: result=%0d we=%b rd=%0d expected 0 1 1", out_alu_result, out_reg_wrenable, out_write_reg);
        end
        clear_inputs();
        in_is_jump = 1'b1; in_pc = 5'd4; in_alu_op = 5'd1; in_write_reg = 5'd1; in_reg_wrenable = 1'b1;
        tick();
        checks++;
        if ({out_reg_wrenable, out_mem_wrenable, out_mem_to_reg} !== 3'b000) begin
            errors++;
            $display("FAIL flush_bubble: we/mwe/m2r=%b expected 000", {out_reg_wrenable, out_mem_wrenable, out_mem_to_reg});
        end
        clear_inputs();
        tick();
        checks++;
        if (out_alu_result !== 32'd5) begin
            errors++;
            $display("FAIL jal_link: got %0d expected 5", out_alu_result);
        end
    endtask

    task automatic test_alu_sweep();
        logic [4:0]  ops [0:11];
        logic [31:0] exp [0:11];
        ops = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd20};
        exp = '{32'h80000001, 32'h7FFFFFFF, 32'h00000000, 32'h80000001, 32'h80000001, 32'h00000000,
                32'h40000000, 32'hC0000000, 32'h00000001, 32'h00000000, 32'h00000001, 32'h00000000};
        for (int i = 0; i < 12; i++) begin
            clear_inputs();
            in_rs1 = 5'd3; in_read_data1 = 32'h80000000; in_imm = 32'd1; in_alu_src = 1'b1;
            in_alu_op = ops[i]; in_write_reg = 5'd9; in_reg_wrenable = 1'b1;
            tick();
            clear_inputs();
            tick();
            checks++;
            if (out_alu_result !== exp[i]) begin
                errors++;
                $display("FAIL alu_op%0d: got %h expected %h", ops[i], out_alu_result, exp[i]);
            end
        end
    endtask

    task automatic test_store_forward();
        clear_inputs();
        in_imm = 32'hDEADBEEF; in_alu_src = 1'b1; in_alu_op = 5'd10; in_write_reg = 5'd5; in_reg_wrenable = 1'b1;
        tick();
        clear_inputs();
        in_rs2 = 5'd5; in_read_data2 = 32'd0; in_imm = 32'd4; in_alu_src = 1'b1; in_mem_wrenable = 1'b1;
        tick();
        clear_inputs();
        tick();
        checks++;
        if (out_store_data !== 32'hDEADBEEF || out_mem_wrenable !== 1'b1 || out_alu_result !== 32'd4 || out_reg_wrenable !== 1'b0) begin
            errors++;
            $display("FAIL store_fwd: data=%h mwe=%b addr=%0d we=%b expected deadbeef 1 4 0",
                     out_store_data, out_mem_wrenable, out_alu_result, out_reg_wrenable);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_wb_forward();
        test_x0();
        test_jump_flush();
        test_alu_sweep();
        test_store_forward();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
